// File: rtl/aes_key_schedule.sv
// Sequential AES-128/192/256 key expansion, one 32-bit word per clock, into a
// word store with a registered 128-bit round-key read port.
module aes_key_schedule #(
    parameter int MAX_NK = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         keys_valid,
    output logic         err,
    output logic [3:0]   nr,
    input  logic [3:0]   rd_round,
    output logic [127:0] rd_data
);

    localparam int WORDS = 4 * (MAX_NK + 7);
    localparam int AW    = $clog2(WORDS);

    typedef enum logic {IDLE, EXPAND} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Inverse as x^254 (maps 0 to 0), then the affine map with constant 0x63
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
        x2   = gmul(x, x);
        x3   = gmul(x2, x);
        x6   = gmul(x3, x3);
        x12  = gmul(x6, x6);
        x15  = gmul(x12, x3);
        x30  = gmul(x15, x15);
        x60  = gmul(x30, x30);
        x120 = gmul(x60, x60);
        x240 = gmul(x120, x120);
        x252 = gmul(x240, x12);
        inv  = gmul(x252, x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    state_t         state, state_nxt;
    logic [31:0]    store     [WORDS];
    logic [31:0]    store_nxt [WORDS];
    logic [AW-1:0]  wi, wlast;
    logic [3:0]     nk_q;
    logic [2:0]     kcnt;
    logic [7:0]     rcon;
    logic [3:0]     nr_q, nr_nxt;
    logic           valid_q, done_q, err_q;
    logic [3:0]     rd_idx;
    logic [127:0]   rd_q, rd_nxt;

    logic [3:0]     nk_in, nr_in;
    logic           legal, accept, reject;
    logic [AW-1:0]  i_prev, i_back;
    logic [31:0]    prev, back, sub_in, sub_out, temp, new_word;
    logic           rot, sub_only, last_word, expanding;

    always_comb begin
        case (key_len)
            2'd0:    nk_in = 4'd4;
            2'd1:    nk_in = 4'd6;
            2'd2:    nk_in = 4'd8;
            default: nk_in = 4'd0;
        endcase
    end

    assign nr_in     = nk_in + 4'd6;
    assign legal     = (key_len != 2'd3) && (int'(nk_in) <= MAX_NK);
    assign accept    = (state == IDLE) && start && legal;
    assign reject    = (state == IDLE) && start && !legal;
    assign expanding = (state == EXPAND);

    // kcnt tracks i mod Nk so no divider is needed
    assign i_prev    = wi - AW'(1);
    assign i_back    = wi - AW'(nk_q);
    assign prev      = store[i_prev];
    assign back      = store[i_back];
    assign rot       = (kcnt == 3'd0);
    assign sub_only  = (nk_q == 4'd8) && (kcnt == 3'd4);
    assign sub_in    = rot ? {prev[23:0], prev[31:24]} : prev;
    assign last_word = (wi == wlast);

    always_comb begin
        for (int b = 0; b < 4; b++) sub_out[8*b +: 8] = sbox(sub_in[8*b +: 8]);
    end

    always_comb begin
        temp = prev;
        if (rot)           temp = sub_out ^ {rcon, 24'h0};
        else if (sub_only) temp = sub_out;
    end

    assign new_word = back ^ temp;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXPAND;
            EXPAND:  if (last_word) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next-state view of the store also feeds the read port, so a read sees
    // a word written on the same edge.
    always_comb begin
        store_nxt = store;
        if (accept) begin
            for (int k = 0; k < MAX_NK; k++) begin
                if (k < int'(nk_in))
                    store_nxt[k] = {key_in[32*k +: 8],      key_in[32*k+8 +: 8],
                                    key_in[32*k+16 +: 8],   key_in[32*k+24 +: 8]};
            end
        end
        if (expanding) store_nxt[wi] = new_word;
    end

    assign nr_nxt = (expanding && last_word) ? (nk_q + 4'd6) : nr_q;

    always_comb begin
        rd_nxt = 128'h0;
        if (rd_idx <= nr_nxt) begin
            for (int j = 0; j < 4; j++)
                rd_nxt[32*j +: 32] = store_nxt[AW'({rd_idx, 2'(j)})];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            for (int k = 0; k < WORDS; k++) store[k] <= 32'h0;
            wi      <= '0;
            wlast   <= '0;
            nk_q    <= 4'd0;
            kcnt    <= 3'd0;
            rcon    <= 8'h01;
            nr_q    <= 4'd0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rd_idx  <= 4'd0;
            rd_q    <= 128'h0;
        end else begin
            state  <= state_nxt;
            store  <= store_nxt;
            nr_q   <= nr_nxt;
            rd_idx <= rd_round;
            rd_q   <= rd_nxt;
            done_q <= expanding && last_word;
            err_q  <= reject;
            if (accept) begin
                wi      <= AW'(nk_in);
                wlast   <= AW'({nr_in, 2'b11});
                nk_q    <= nk_in;
                kcnt    <= 3'd0;
                rcon    <= 8'h01;
                valid_q <= 1'b0;
            end else if (expanding) begin
                wi   <= wi + AW'(1);
                kcnt <= ({1'b0, kcnt} == nk_q - 4'd1) ? 3'd0 : kcnt + 3'd1;
                if (rot) rcon <= xtime(rcon);
                if (last_word) valid_q <= 1'b1;
            end
        end
    end

    assign busy       = expanding;
    assign done       = done_q;
    assign err        = err_q;
    assign keys_valid = valid_q;
    assign nr         = nr_q;
    assign rd_data    = rd_q;

endmodule
